// File: rtl/axi_decouple_tracker.sv
// axi_decouple_tracker
//   Sits between an accessor's AXI4 master and the MMU slave port. Payload
//   passes straight through with no registers. Only the handshakes are gated.
//   The block counts outstanding reads and writes and caps each direction at
//   MAX_OUTSTANDING. On a decouple request it stops taking new addresses,
//   lets in-flight bursts finish, and then reports a clean, isolated state.
// Ports:
//   aclk, areset            clock, async active-high reset
//   axi_s_{aw,w,b,ar,r}*    slave side, facing the accessor
//   axi_m_{aw,w,b,ar,r}*    master side, facing the MMU
//   decouple                level request to drain and isolate
//   decouple_done           high while in DECOUPLED
//   wr/rd_outstanding       accepted-but-unfinished transaction counts
//   protocol_err            sticky; a B or RLAST arrived with its count at 0
module axi_decouple_tracker #(
  parameter int AXI_ID_WIDTH    = 5,
  parameter int AXI_ADDR_WIDTH  = 31,
  parameter int AXI_DATA_WIDTH  = 128,
  parameter int MAX_OUTSTANDING = 16
) (
  input  logic                                     aclk,
  input  logic                                     areset,
  // accessor side
  input  logic [AXI_ID_WIDTH-1:0]                  axi_s_awid,
  input  logic [AXI_ADDR_WIDTH-1:0]                axi_s_awaddr,
  input  logic [7:0]                               axi_s_awlen,
  input  logic [2:0]                               axi_s_awsize,
  input  logic [1:0]                               axi_s_awburst,
  input  logic                                     axi_s_awvalid,
  output logic                                     axi_s_awready,
  input  logic [AXI_DATA_WIDTH-1:0]                axi_s_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0]              axi_s_wstrb,
  input  logic                                     axi_s_wlast,
  input  logic                                     axi_s_wvalid,
  output logic                                     axi_s_wready,
  output logic [AXI_ID_WIDTH-1:0]                  axi_s_bid,
  output logic [1:0]                               axi_s_bresp,
  output logic                                     axi_s_bvalid,
  input  logic                                     axi_s_bready,
  input  logic [AXI_ID_WIDTH-1:0]                  axi_s_arid,
  input  logic [AXI_ADDR_WIDTH-1:0]                axi_s_araddr,
  input  logic [7:0]                               axi_s_arlen,
  input  logic [2:0]                               axi_s_arsize,
  input  logic [1:0]                               axi_s_arburst,
  input  logic                                     axi_s_arvalid,
  output logic                                     axi_s_arready,
  output logic [AXI_ID_WIDTH-1:0]                  axi_s_rid,
  output logic [AXI_DATA_WIDTH-1:0]                axi_s_rdata,
  output logic [1:0]                               axi_s_rresp,
  output logic                                     axi_s_rlast,
  output logic                                     axi_s_rvalid,
  input  logic                                     axi_s_rready,
  // MMU side
  output logic [AXI_ID_WIDTH-1:0]                  axi_m_awid,
  output logic [AXI_ADDR_WIDTH-1:0]                axi_m_awaddr,
  output logic [7:0]                               axi_m_awlen,
  output logic [2:0]                               axi_m_awsize,
  output logic [1:0]                               axi_m_awburst,
  output logic                                     axi_m_awvalid,
  input  logic                                     axi_m_awready,
  output logic [AXI_DATA_WIDTH-1:0]                axi_m_wdata,
  output logic [AXI_DATA_WIDTH/8-1:0]              axi_m_wstrb,
  output logic                                     axi_m_wlast,
  output logic                                     axi_m_wvalid,
  input  logic                                     axi_m_wready,
  input  logic [AXI_ID_WIDTH-1:0]                  axi_m_bid,
  input  logic [1:0]                               axi_m_bresp,
  input  logic                                     axi_m_bvalid,
  output logic                                     axi_m_bready,
  output logic [AXI_ID_WIDTH-1:0]                  axi_m_arid,
  output logic [AXI_ADDR_WIDTH-1:0]                axi_m_araddr,
  output logic [7:0]                               axi_m_arlen,
  output logic [2:0]                               axi_m_arsize,
  output logic [1:0]                               axi_m_arburst,
  output logic                                     axi_m_arvalid,
  input  logic                                     axi_m_arready,
  input  logic [AXI_ID_WIDTH-1:0]                  axi_m_rid,
  input  logic [AXI_DATA_WIDTH-1:0]                axi_m_rdata,
  input  logic [1:0]                               axi_m_rresp,
  input  logic                                     axi_m_rlast,
  input  logic                                     axi_m_rvalid,
  output logic                                     axi_m_rready,
  // control / status
  input  logic                                     decouple,
  output logic                                     decouple_done,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]     wr_outstanding,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]     rd_outstanding,
  output logic                                     protocol_err
);
  localparam int CW = $clog2(MAX_OUTSTANDING+1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {RUN, DRAIN, DECOUPLED} state_t;
  state_t state, state_n;

  logic          aw_hold, ar_hold;
  logic [CW-1:0] w_bursts;
  logic          aw_open, ar_open, w_open;
  logic          aw_hs, ar_hs, wlast_hs, b_hs, rlast_hs;
  logic          wr_err, rd_err, drained;

  // A held request re-opens its channel so that a valid already shown to
  // the MMU is never withdrawn. This holds even through decouple or the cap.
  assign aw_open = ((state == RUN) && (wr_outstanding < MAX_CNT)) || aw_hold;
  assign ar_open = ((state == RUN) && (rd_outstanding < MAX_CNT)) || ar_hold;
  // W follows accepted AWs only. Decouple never blocks W, so bursts finish.
  assign w_open  = (w_bursts != '0) || aw_hs;

  // Payload pass-through
  assign axi_m_awid    = axi_s_awid;
  assign axi_m_awaddr  = axi_s_awaddr;
  assign axi_m_awlen   = axi_s_awlen;
  assign axi_m_awsize  = axi_s_awsize;
  assign axi_m_awburst = axi_s_awburst;
  assign axi_m_wdata   = axi_s_wdata;
  assign axi_m_wstrb   = axi_s_wstrb;
  assign axi_m_wlast   = axi_s_wlast;
  assign axi_s_bid     = axi_m_bid;
  assign axi_s_bresp   = axi_m_bresp;
  assign axi_m_arid    = axi_s_arid;
  assign axi_m_araddr  = axi_s_araddr;
  assign axi_m_arlen   = axi_s_arlen;
  assign axi_m_arsize  = axi_s_arsize;
  assign axi_m_arburst = axi_s_arburst;
  assign axi_s_rid     = axi_m_rid;
  assign axi_s_rdata   = axi_m_rdata;
  assign axi_s_rresp   = axi_m_rresp;
  assign axi_s_rlast   = axi_m_rlast;

  // Handshake gating
  assign axi_m_awvalid = axi_s_awvalid & aw_open;
  assign axi_s_awready = axi_m_awready & aw_open;
  assign axi_m_arvalid = axi_s_arvalid & ar_open;
  assign axi_s_arready = axi_m_arready & ar_open;
  assign axi_m_wvalid  = axi_s_wvalid  & w_open;
  assign axi_s_wready  = axi_m_wready  & w_open;
  assign axi_s_bvalid  = axi_m_bvalid;
  assign axi_m_bready  = axi_s_bready;
  assign axi_s_rvalid  = axi_m_rvalid;
  assign axi_m_rready  = axi_s_rready;

  assign aw_hs    = axi_m_awvalid & axi_m_awready;
  assign ar_hs    = axi_m_arvalid & axi_m_arready;
  assign wlast_hs = axi_m_wvalid & axi_m_wready & axi_s_wlast;
  assign b_hs     = axi_m_bvalid & axi_s_bready;
  assign rlast_hs = axi_m_rvalid & axi_s_rready & axi_m_rlast;

  // A lone decrement at zero is a response with no matching request.
  assign wr_err = b_hs & ~aw_hs & (wr_outstanding == '0);
  assign rd_err = rlast_hs & ~ar_hs & (rd_outstanding == '0);

  assign drained = (wr_outstanding == '0) && (rd_outstanding == '0) &&
                   (w_bursts == '0) && !aw_hold && !ar_hold;

  // Simultaneous inc/dec cancel. A decrement at zero saturates.
  function automatic logic [CW-1:0] cnt_next(input logic [CW-1:0] c,
                                             input logic inc, input logic dec);
    if (inc && !dec)                return c + 1'b1;
    else if (dec && !inc && c != '0) return c - 1'b1;
    else                            return c;
  endfunction

  always_comb begin
    state_n = state;
    case (state)
      RUN:       if (decouple) state_n = DRAIN;
      DRAIN:     if (!decouple) state_n = RUN;
                 else if (drained) state_n = DECOUPLED;
      DECOUPLED: if (!decouple) state_n = RUN;
      default:   state_n = RUN;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state          <= RUN;
      decouple_done  <= 1'b0;
      aw_hold        <= 1'b0;
      ar_hold        <= 1'b0;
      w_bursts       <= '0;
      wr_outstanding <= '0;
      rd_outstanding <= '0;
      protocol_err   <= 1'b0;
    end else begin
      state          <= state_n;
      decouple_done  <= (state_n == DECOUPLED);
      aw_hold        <= aw_hs ? 1'b0 : (axi_m_awvalid | aw_hold);
      ar_hold        <= ar_hs ? 1'b0 : (axi_m_arvalid | ar_hold);
      w_bursts       <= cnt_next(w_bursts, aw_hs, wlast_hs);
      wr_outstanding <= cnt_next(wr_outstanding, aw_hs, b_hs);
      rd_outstanding <= cnt_next(rd_outstanding, ar_hs, rlast_hs);
      protocol_err   <= protocol_err | wr_err | rd_err;
    end
  end
endmodule

// File: doc/axi_decouple_tracker.md
Name: axi_decouple_tracker

Overview:
- Sits directly upstream of the address-remapping MMU, between an accessor's AXI4 master and the MMU slave port.
- Counts outstanding read and write transactions and caps them at a limit.
- On request, stops accepting new requests, drains in-flight traffic, then reports a clean decoupled state so the accessor can be reset or reconfigured without orphaning bursts.
- Data path is zero-latency pass-through; only gating and control are registered.

Parameters:
AXI_ID_WIDTH, 5, width of all AXI ID fields
AXI_ADDR_WIDTH, 31, address width (same on both sides; MMU input width)
AXI_DATA_WIDTH, 128, data path width
MAX_OUTSTANDING, 16, max accepted-but-unfinished transactions per direction; counters are $clog2(MAX_OUTSTANDING+1) bits

Ports:
aclk  in  1  clock, all interfaces synchronous
areset  in  1  asynchronous, active-high reset
axi_s_aw{id,addr,len,size,burst,valid}/awready  in/out  per AXI4  write address from accessor
axi_s_w{data,strb,last,valid}/wready  in/out  per AXI4  write data from accessor
axi_s_b{id,resp,valid}/bready  out/in  per AXI4  write response to accessor
axi_s_ar{id,addr,len,size,burst,valid}/arready  in/out  per AXI4  read address from accessor
axi_s_r{id,data,resp,last,valid}/rready  out/in  per AXI4  read data to accessor
axi_m_*  mirror of axi_s_*  per AXI4  same five channels toward the MMU
decouple  in  1  level request to drain and isolate
decouple_done  out  1  high only in DECOUPLED
wr_outstanding  out  cnt  AW accepted minus B accepted
rd_outstanding  out  cnt  AR accepted minus RLAST accepted
protocol_err  out  1  sticky: B or RLAST seen with its counter at 0

Behaviour:
Reset values:
- state=RUN.
- All counters=0.
- aw_hold, ar_hold, decouple_done and protocol_err=0.
- Combinational outputs follow from these values.

Pass-through:
- All payload fields pass combinationally. There are no pipeline registers.

Address gating (AW and AR are symmetric):
- A channel is open when state==RUN and its counter < MAX_OUTSTANDING, or when its hold bit is 1.
- axi_m_awvalid = axi_s_awvalid & open.
- axi_s_awready = axi_m_awready & open.
- aw_hold is set when axi_m_awvalid=1 and axi_m_awready=0. It is cleared on the AW handshake.
- Once presented to the MMU, a request stays valid until accepted, even if decouple rises or the limit is reached. This preserves AXI valid stability.

Write data:
- w_bursts counts AW accepted minus WLAST accepted.
- W passes only when w_bursts>0, or when an AW handshake occurs in the same cycle.
- Otherwise axi_m_wvalid=0 and axi_s_wready=0.
- W is never blocked by decouple, so accepted bursts always complete.

Responses:
- B and R always pass.
- wr_outstanding decrements on a B handshake.
- rd_outstanding decrements on an R handshake with rlast=1.

Counter updates:
- An increment and a decrement in the same cycle leave the counter unchanged.
- A decrement at 0 holds the counter at 0 and sets protocol_err.
- Increment at MAX is impossible because gating closes the channel.

FSM:
- RUN -> DRAIN when decouple=1.
- DRAIN -> DECOUPLED when both counters, w_bursts, aw_hold and ar_hold are all 0.
- DRAIN -> RUN when decouple=0.
- DECOUPLED -> RUN when decouple=0.
- decouple_done is registered: it goes high the cycle after the drain condition is met.

Reset mid-burst:
- Asynchronous reset returns everything to reset values immediately. The downstream side must be reset together with this block.

Test Plan:
- Single AW (len=3) plus 4 W beats plus B in RUN -> all pass with zero latency; wr_outstanding goes 0->1->0; decouple_done stays 0.
- Issue 16 ARs with arready=1 and rvalid held off -> 17th AR sees axi_s_arready=0; after one RLAST, rd_outstanding=15 and the next AR is accepted.
- Hold axi_m_awready=0 with AW valid, then raise decouple -> axi_m_awvalid stays 1 until handshake; state DRAIN; decouple_done rises 1 cycle after the final B.
- In DECOUPLED, drive a new AW/AR -> axi_s_awready and axi_s_arready stay 0; drop decouple -> RUN next cycle and the request is accepted.
- In the same cycle, B handshake and new AW handshake at wr_outstanding=5 -> stays 5. Inject B at count 0 -> count stays 0 and protocol_err=1 until areset.
- Assert areset during a 4-beat write after 2 beats -> all counters 0, state RUN and decouple_done 0 immediately.
